// File: rtl/sorted_vector_drain.sv
// sorted_vector_drain: captures one sorted vector (data plus original
// indices) from the bitonic merge network, streams it out one element per
// cycle over valid/ready, and records the inverse permutation (rank of each
// original input position) together with a duplicate-index flag.
module sorted_vector_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int N_INPUTS    = 8,
    parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [N_INPUTS*INDEX_WIDTH-1:0] in_idx,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [INDEX_WIDTH-1:0]          out_idx,
    output logic [INDEX_WIDTH-1:0]          out_pos,
    output logic                            out_last,
    output logic                            rank_valid,
    output logic [N_INPUTS*INDEX_WIDTH-1:0] rank_vec,
    output logic                            perm_err
);

    localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(N_INPUTS - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                            state_q;
    logic [N_INPUTS*DATA_WIDTH-1:0]    data_q;
    logic [N_INPUTS*INDEX_WIDTH-1:0]   idx_q;
    logic [INDEX_WIDTH-1:0]            posCnt_q;
    logic [N_INPUTS*INDEX_WIDTH-1:0]   rankVec_q;
    logic [N_INPUTS*INDEX_WIDTH-1:0]   rankVec_d;
    logic                              permErr_q;
    logic                              permErr_d;
    logic                              rankValid_q;
    logic [N_INPUTS-1:0]               seen;
    logic [INDEX_WIDTH-1:0]            origIdx;

    // Inverse permutation of the incoming indices: later positions overwrite
    // earlier ones on duplicates, and any index seen twice raises the error.
    always_comb begin
        rankVec_d = '0;
        permErr_d = 1'b0;
        seen      = '0;
        origIdx   = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            origIdx = in_idx[k*INDEX_WIDTH +: INDEX_WIDTH];
            if (seen[origIdx]) begin
                permErr_d = 1'b1;
            end
            seen[origIdx] = 1'b1;
            rankVec_d[int'(origIdx)*INDEX_WIDTH +: INDEX_WIDTH] = INDEX_WIDTH'(k);
        end
    end

    // Capture/drain state machine; the captured vector is only replaced from
    // IDLE, so a vector in flight can never be overwritten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            posCnt_q    <= '0;
            rankVec_q   <= '0;
            permErr_q   <= 1'b0;
            rankValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q      <= in_data;
                        idx_q       <= in_idx;
                        posCnt_q    <= '0;
                        rankVec_q   <= rankVec_d;
                        permErr_q   <= permErr_d;
                        rankValid_q <= 1'b1;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (posCnt_q == LAST_POS) begin
                            state_q <= IDLE;
                        end else begin
                            posCnt_q <= posCnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded purely from registered state, so nothing on the
    // input side reaches the output side within a cycle.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DRAIN);
    assign out_data   = out_valid ? data_q[int'(posCnt_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign out_idx    = out_valid ? idx_q[int'(posCnt_q)*INDEX_WIDTH +: INDEX_WIDTH] : '0;
    assign out_pos    = out_valid ? posCnt_q : '0;
    assign out_last   = out_valid && (posCnt_q == LAST_POS);
    assign rank_valid = rankValid_q;
    assign rank_vec   = rankVec_q;
    assign perm_err   = permErr_q;

endmodule
